fetch_ctrl: RTL and testbench

- F-stage sequencer that owns the architectural PC and drives the instruction-memory request/acknowledge handshake.
- Takes the next-PC value computed by the next-PC logic and applies it when D consumes the current instruction.
- Overrides the PC on interrupt/exception entry (handler vector) and on ERET (EPC).
- Presents a registered instruction, its PC and a fetch-address-error flag to the D stage.

---
 rtl/fetch_ctrl.sv | 155 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: F-stage sequencer owning the architectural PC.
// Drives the imem req/ack handshake and presents a registered instruction to D.
//
// Ports:
//   clk         system clock, all state updates on rising edge
//   reset       synchronous active-low reset (0 = reset)
//   npc         next PC from next-PC logic, used when D consumes
//   d_stall     D cannot accept the instruction this cycle
//   int_req     exception/interrupt entry, redirect to HANDLER_PC
//   eret        return from exception, redirect to epc
//   epc         exception return address
//   imem_req    instruction-memory request (state == REQ)
//   imem_addr   fetch address, equals pc
//   imem_ack    memory returns data this cycle
//   imem_rdata  instruction word, valid with imem_ack
//   pc          current architectural fetch PC
//   f_valid     f_instr/f_pc hold a fetched instruction
//   f_instr     instruction to D
//   f_pc        PC of f_instr
//   adel_f      fetch address error for f_instr
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
   parameter logic [31:0] IMEM_LO    = 32'h0000_3000,
   parameter logic [31:0] IMEM_HI    = 32'h0000_6FFC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] npc,
   input  logic        d_stall,
   input  logic        int_req,
   input  logic        eret,
   input  logic [31:0] epc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc,
   output logic        f_valid,
   output logic [31:0] f_instr,
   output logic [31:0] f_pc,
   output logic        adel_f
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_FULL = 2'd1,
      S_BAD  = 2'd2
   } state_t;

   state_t      state, state_n;
   logic [31:0] pc_n;
   logic        discard, discard_n;
   logic        f_valid_n;
   logic [31:0] f_instr_n;
   logic [31:0] f_pc_n;
   logic        adel_n;

   logic        redirect;
   logic [31:0] target;

   function automatic logic legal(input logic [31:0] a);
      return (a[1:0] == 2'b00) && (a >= IMEM_LO) && (a <= IMEM_HI);
   endfunction

   assign imem_req  = (state == S_REQ);
   assign imem_addr = pc;

   assign redirect = int_req | eret;
   assign target   = int_req ? HANDLER_PC : epc;

   always_comb begin
      state_n   = state;
      pc_n      = pc;
      discard_n = discard;
      f_valid_n = f_valid;
      f_instr_n = f_instr;
      f_pc_n    = f_pc;
      adel_n    = adel_f;

      unique case (state)
         S_REQ: begin
            if (imem_ack) begin
               if (discard) begin
                  // Stale data from a request abandoned by a redirect.
                  discard_n = 1'b0;
                  state_n   = legal(pc) ? S_REQ : S_BAD;
               end else begin
                  f_instr_n = imem_rdata;
                  f_pc_n    = pc;
                  f_valid_n = 1'b1;
                  adel_n    = 1'b0;
                  state_n   = S_FULL;
               end
            end
         end
         S_FULL: begin
            if (!d_stall) begin
               pc_n      = npc;
               f_valid_n = 1'b0;
               state_n   = legal(npc) ? S_REQ : S_BAD;
            end
         end
         S_BAD: begin
            // Deliver a nop flagged with the address error.
            f_valid_n = 1'b1;
            f_instr_n = 32'h0;
            f_pc_n    = pc;
            adel_n    = 1'b1;
            state_n   = S_FULL;
         end
         default: begin
            state_n = S_REQ;
         end
      endcase

      // Redirect overrides stall and consume.
      if (redirect) begin
         pc_n      = target;
         f_valid_n = 1'b0;
         f_instr_n = f_instr;
         f_pc_n    = f_pc;
         adel_n    = 1'b0;
         if (state == S_REQ && !imem_ack) begin
            // Outstanding request must finish; drop its data later.
            discard_n = 1'b1;
            state_n   = S_REQ;
         end else begin
            discard_n = 1'b0;
            state_n   = legal(target) ? S_REQ : S_BAD;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= S_REQ;
         pc      <= RESET_PC;
         discard <= 1'b0;
         f_valid <= 1'b0;
         f_instr <= 32'h0;
         f_pc    <= 32'h0;
         adel_f  <= 1'b0;
      end else begin
         state   <= state_n;
         pc      <= pc_n;
         discard <= discard_n;
         f_valid <= f_valid_n;
         f_instr <= f_instr_n;
         f_pc    <= f_pc_n;
         adel_f  <= adel_n;
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed bench for fetch_ctrl.
// Expected deliveries are queued by stimulus and checked by a monitor.
module tb_fetch_ctrl;

   logic        clk;
   logic        reset;
   logic [31:0] npc;
   logic        d_stall;
   logic        int_req;
   logic        eret;
   logic [31:0] epc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] pc;
   logic        f_valid;
   logic [31:0] f_instr;
   logic [31:0] f_pc;
   logic        adel_f;

   logic        npc_ovr_en;
   logic [31:0] npc_ovr;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        adel;
   } exp_t;

   exp_t q[$];
   int   checks;
   int   failures;
   logic prev_fv;

   fetch_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .npc        (npc),
      .d_stall    (d_stall),
      .int_req    (int_req),
      .eret       (eret),
      .epc        (epc),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .pc         (pc),
      .f_valid    (f_valid),
      .f_instr    (f_instr),
      .f_pc       (f_pc),
      .adel_f     (adel_f)
   );

   // Next-PC logic stand-in: sequential unless a test forces a value.
   assign npc = npc_ovr_en ? npc_ovr : pc + 32'd4;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] p, input logic [31:0] i,
                       input logic a);
      exp_t e;
      e.pc    = p;
      e.instr = i;
      e.adel  = a;
      q.push_back(e);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Monitor: each new instruction shows up as a rising f_valid.
   initial begin
      prev_fv = 1'b0;
      forever begin
         @(negedge clk);
         if (f_valid && !prev_fv) begin
            checks++;
            if (q.size() == 0) begin
               failures++;
               $display("FAIL deliver: unexpected f_pc %h f_instr %h",
                        f_pc, f_instr);
            end else begin
               exp_t e;
               e = q.pop_front();
               if (f_pc !== e.pc || f_instr !== e.instr
                   || adel_f !== e.adel) begin
                  failures++;
                  $display("FAIL deliver: got pc %h ins %h adel %b expected pc %h ins %h adel %b",
                           f_pc, f_instr, adel_f, e.pc, e.instr, e.adel);
               end
            end
         end
         prev_fv = f_valid;
      end
   end

   initial begin
      checks     = 0;
      failures   = 0;
      reset      = 1'b0;
      d_stall    = 1'b0;
      int_req    = 1'b0;
      eret       = 1'b0;
      epc        = 32'h0;
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
      npc_ovr_en = 1'b0;
      npc_ovr    = 32'h0;

      tick();
      tick();
      chk("rst_pc", pc, 32'h3000);
      chk("rst_fv", {31'h0, f_valid}, 32'h0);
      chk("rst_instr", f_instr, 32'h0);
      chk("rst_fpc", f_pc, 32'h0);
      chk("rst_adel", {31'h0, adel_f}, 32'h0);

      // 1: zero-wait streaming
      reset      = 1'b1;
      imem_ack   = 1'b1;
      imem_rdata = 32'h2408_0001;
      chk("t1_addr0", imem_addr, 32'h3000);
      chk("t1_req0", {31'h0, imem_req}, 32'h1);
      push(32'h3000, 32'h2408_0001, 1'b0);
      tick();
      chk("t1_req1", {31'h0, imem_req}, 32'h0);
      tick();
      chk("t1_addr2", imem_addr, 32'h3004);
      chk("t1_req2", {31'h0, imem_req}, 32'h1);
      push(32'h3004, 32'h2408_0001, 1'b0);
      tick();
      tick();
      chk("t1_addr4", imem_addr, 32'h3008);
      push(32'h3008, 32'h2408_0001, 1'b0);
      tick();

      // 2: stall holds FULL
      d_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t2_pc", pc, 32'h3008);
         chk("t2_fv", {31'h0, f_valid}, 32'h1);
         chk("t2_fpc", f_pc, 32'h3008);
         chk("t2_req", {31'h0, imem_req}, 32'h0);
      end
      d_stall = 1'b0;
      tick();
      chk("t2_req_after", {31'h0, imem_req}, 32'h1);
      chk("t2_addr_after", imem_addr, 32'h300C);

      // 3: interrupt while a request is outstanding
      imem_ack = 1'b0;
      int_req  = 1'b1;
      tick();
      int_req = 1'b0;
      chk("t3_pc", pc, 32'h4180);
      chk("t3_fv", {31'h0, f_valid}, 32'h0);
      tick();
      tick();
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      tick();
      chk("t3_drop_fv", {31'h0, f_valid}, 32'h0);
      chk("t3_req", {31'h0, imem_req}, 32'h1);
      chk("t3_addr", imem_addr, 32'h4180);
      imem_rdata = 32'h2408_0002;
      push(32'h4180, 32'h2408_0002, 1'b0);
      tick();

      // 4: eret during stall, then int_req+eret together
      d_stall = 1'b1;
      eret    = 1'b1;
      epc     = 32'h3010;
      tick();
      eret    = 1'b0;
      d_stall = 1'b0;
      chk("t4_fv", {31'h0, f_valid}, 32'h0);
      chk("t4_addr", imem_addr, 32'h3010);
      chk("t4_req", {31'h0, imem_req}, 32'h1);
      push(32'h3010, 32'h2408_0002, 1'b0);
      tick();
      d_stall = 1'b1;
      int_req = 1'b1;
      eret    = 1'b1;
      epc     = 32'h3020;
      tick();
      int_req = 1'b0;
      eret    = 1'b0;
      chk("t4_both_pc", pc, 32'h4180);
      chk("t4_both_fv", {31'h0, f_valid}, 32'h0);
      imem_rdata = 32'h2408_0003;
      push(32'h4180, 32'h2408_0003, 1'b0);
      tick();

      // 5: illegal and boundary next-PC values
      d_stall    = 1'b0;
      npc_ovr_en = 1'b1;
      npc_ovr    = 32'h3002;
      tick();
      chk("t5_misal_req", {31'h0, imem_req}, 32'h0);
      chk("t5_misal_pc", pc, 32'h3002);
      push(32'h3002, 32'h0, 1'b1);
      tick();
      chk("t5_misal_adel", {31'h0, adel_f}, 32'h1);
      npc_ovr = 32'h7000;
      tick();
      chk("t5_hi_req", {31'h0, imem_req}, 32'h0);
      push(32'h7000, 32'h0, 1'b1);
      tick();
      npc_ovr = 32'h6FFC;
      tick();
      chk("t5_top_req", {31'h0, imem_req}, 32'h1);
      chk("t5_top_addr", imem_addr, 32'h6FFC);
      push(32'h6FFC, 32'h2408_0003, 1'b0);
      tick();
      npc_ovr = 32'h2FFC;
      tick();
      chk("t5_lo_req", {31'h0, imem_req}, 32'h0);
      push(32'h2FFC, 32'h0, 1'b1);
      tick();

      // 6: reset mid-request, stale ack taken as the reset fetch
      npc_ovr  = 32'h3100;
      imem_ack = 1'b0;
      tick();
      chk("t6_addr", imem_addr, 32'h3100);
      tick();
      reset = 1'b0;
      tick();
      chk("t6_pc", pc, 32'h3000);
      chk("t6_fv", {31'h0, f_valid}, 32'h0);
      chk("t6_fpc", f_pc, 32'h0);
      chk("t6_instr", f_instr, 32'h0);
      reset = 1'b1;
      tick();
      chk("t6_req", {31'h0, imem_req}, 32'h1);
      chk("t6_addr_rst", imem_addr, 32'h3000);
      imem_ack   = 1'b1;
      imem_rdata = 32'h2408_0004;
      push(32'h3000, 32'h2408_0004, 1'b0);
      tick();
      d_stall  = 1'b1;
      imem_ack = 1'b0;
      tick();
      tick();
      chk("queue_empty", q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
